// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the mem_pipe memory block.
//   mem_state_e : clear-engine / request FSM states
//   RD_LAT_MIN/RD_LAT_MAX : legal read-latency range
//   depth()     : number of words addressed by an ADDR_W-bit address
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic {
        MS_CLEAR,
        MS_READY
    } mem_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    function automatic int depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/mem_pipe_if.sv
// -----------------------------------------------------------------------------
// mem_pipe_if
// Memory bus between a requester (master) and mem_pipe (slave).
//   clr       : clear request (master -> slave)
//   req_valid : request present; read/write select the operation
//   req_ready : slave can accept a request
//   addr      : word address
//   data_in   : write data
//   data_out  : read data, holds the last read value
//   rd_valid  : one-cycle strobe when data_out carries new read data
//   busy      : clear engine active
//   err       : sticky illegal-request flag
// -----------------------------------------------------------------------------
interface mem_pipe_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              clr;
    logic              req_valid;
    logic              req_ready;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              busy;
    logic              err;

    modport master (
        output clr, req_valid, read, write, addr, data_in,
        input  req_ready, data_out, rd_valid, busy, err
    );

    modport slave (
        input  clr, req_valid, read, write, addr, data_in,
        output req_ready, data_out, rd_valid, busy, err
    );
endinterface

// File: rtl/mem_rd_pipe.sv
// -----------------------------------------------------------------------------
// mem_rd_pipe
// RD_LAT-stage valid/data delay line for the read path.
//   clk     : clock
//   flush_i : synchronous flush, active-high; clears valids and data
//   vld_i   : new read data presented this cycle
//   data_i  : read data
//   vld_o   : valid leaving the last stage
//   data_o  : data of the last stage; holds the last valid value
// Each stage only reloads its data when a valid word arrives, so the last
// stage naturally holds the most recent read result between reads.
// -----------------------------------------------------------------------------
module mem_rd_pipe #(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              flush_i,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o
);

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            logic              vld_q;
            logic [DATA_W-1:0] data_q;
            logic              vld_in;
            logic [DATA_W-1:0] data_in;

            if (gi == 0) begin : g_head
                assign vld_in  = vld_i;
                assign data_in = data_i;
            end else begin : g_link
                assign vld_in  = g_stage[gi-1].vld_q;
                assign data_in = g_stage[gi-1].data_q;
            end

            always_ff @(posedge clk) begin
                if (flush_i) begin
                    vld_q  <= 1'b0;
                    data_q <= '0;
                end else begin
                    vld_q <= vld_in;
                    if (vld_in) begin
                        data_q <= data_in;
                    end
                end
            end
        end
    endgenerate

    assign vld_o  = g_stage[RD_LAT-1].vld_q;
    assign data_o = g_stage[RD_LAT-1].data_q;

endmodule

// File: rtl/mem_pipe.sv
// -----------------------------------------------------------------------------
// mem_pipe
// Parametrised single-port synchronous memory with request handshake,
// RD_LAT-cycle read pipeline, hardware clear engine and sticky error flag.
//   clk  : clock, all state changes on posedge
//   rst_ : synchronous reset, active-low; flushes reads, clears err and
//          restarts the clear engine from word 0
//   bus  : mem_pipe_if slave port (handshake, data, status)
// The word array is kept as memory[0:DEPTH-1] so it can be inspected
// hierarchically.
// -----------------------------------------------------------------------------
module mem_pipe
    import mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_,
    mem_pipe_if.slave   bus
);

    localparam int DEPTH = depth(ADDR_W);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $fatal(1, "mem_pipe: RD_LAT must be within 1..4");
    end
    if (DATA_W < 1 || DATA_W > 64) begin : g_bad_data_w
        $fatal(1, "mem_pipe: DATA_W must be within 1..64");
    end

    logic [DATA_W-1:0] memory [0:DEPTH-1];

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              err_q, err_d;

    logic              accept;
    logic              op_rd;
    logic              op_wr;
    logic              op_bad;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              pipe_vld;
    logic [DATA_W-1:0] pipe_data;

    // Requests arriving in a reset cycle are dropped so reset never
    // races a write or a pipeline entry.
    assign accept = bus.req_valid && bus.req_ready && rst_;
    assign op_rd  = accept &&  bus.read && !bus.write;
    assign op_wr  = accept && !bus.read &&  bus.write;
    assign op_bad = accept && (bus.read == bus.write);

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        bus.busy      = 1'b0;
        bus.req_ready = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = bus.addr;
        mem_wdata     = bus.data_in;

        case (state_q)
            MS_CLEAR: begin
                bus.busy  = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = MS_READY;
                end
            end
            MS_READY: begin
                bus.req_ready = 1'b1;
                mem_we        = op_wr;
                // The request of this cycle still executes; the clear
                // starts on the following cycle.
                if (bus.clr) begin
                    state_d = MS_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = MS_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign err_d = err_q || op_bad;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q <= MS_CLEAR;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && rst_) begin
            memory[mem_waddr] <= mem_wdata;
        end
    end

    // Stage 0 of the pipe captures the array at the acceptance edge,
    // which acts as the registered read port.
    mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .flush_i (!rst_),
        .vld_i   (op_rd),
        .data_i  (memory[bus.addr]),
        .vld_o   (pipe_vld),
        .data_o  (pipe_data)
    );

    assign bus.rd_valid = pipe_vld;
    assign bus.data_out = pipe_data;
    assign bus.err      = err_q;

endmodule
